// File: rtl/unit_selector.sv
// Keyboard-driven cursor over NUM_UNITS selectable units. Steps skip dead units, a held
// key auto-repeats, and the confirm key latches the chosen index.
module unit_selector #(
  parameter int          NUM_UNITS     = 4,
  parameter int          IDX_W         = 2,
  parameter logic [7:0]  KEY_PREV      = 8'h14,
  parameter logic [7:0]  KEY_NEXT      = 8'h08,
  parameter logic [7:0]  KEY_CONFIRM   = 8'h28,
  parameter logic [1:0]  SELECT_STATE  = 2'd0,
  parameter bit          WRAP          = 1'b1,
  parameter int          REPEAT_DELAY  = 24,
  parameter int          REPEAT_PERIOD = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [7:0]           keycode,
  input  logic [1:0]           currentState,
  input  logic [NUM_UNITS-1:0] alive_mask,
  output logic [IDX_W-1:0]     sel_idx,
  output logic                 sel_valid,
  output logic                 sel_changed,
  output logic                 confirm_pulse,
  output logic [IDX_W-1:0]     confirmed_idx
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;

  logic [IDX_W-1:0] selQ, selD;
  logic [IDX_W-1:0] confIdxQ, confIdxD;
  logic             changedQ, changedD;
  logic             confPulseQ, confPulseD;
  logic [7:0]       prevKeyQ;
  logic             armedQ;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             repQ, repD;

  logic active, anyAlive, selValid, isStepKey, pressed, tick;
  logic stepUp, stepDown;
  logic [IDX_W:0] stepHit, deadHit;

  // Nearest alive index strictly away from 'from' in the given direction; MSB flags a hit.
  // Iterating from the far end down lets the closest candidate win.
  function automatic logic [IDX_W:0] findAlive(input logic [IDX_W-1:0] from, input logic up,
                                               input logic wrap, input logic [NUM_UNITS-1:0] mask);
    logic [IDX_W:0] res;
    int             cand;
    logic           hit;
    res = '0;
    for (int d = NUM_UNITS - 1; d >= 1; d--) begin
      cand = up ? int'(from) + d : int'(from) - d;
      if (cand >= NUM_UNITS) cand = wrap ? cand - NUM_UNITS : -1;
      else if (cand < 0)     cand = wrap ? cand + NUM_UNITS : -1;
      hit = 1'b0;
      for (int i = 0; i < NUM_UNITS; i++)
        if (cand == i) hit = mask[i];
      if (hit) res = {1'b1, IDX_W'(cand)};
    end
    return res;
  endfunction

  always_comb begin
    selValid = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++)
      if (selQ == IDX_W'(i)) selValid = alive_mask[i];
  end

  assign active    = (currentState == SELECT_STATE);
  assign anyAlive  = (alive_mask != '0);
  assign isStepKey = (keycode == KEY_PREV) || (keycode == KEY_NEXT);
  // armedQ is low only for the first edge after reset, so a key held through reset never fires
  assign pressed   = armedQ && active && (keycode != prevKeyQ);

  // Auto-repeat counter: starts only from a genuine press, then delay phase, then period phase
  always_comb begin
    cntD = '0;
    repD = 1'b0;
    tick = 1'b0;
    if (active && armedQ && isStepKey) begin
      if (pressed) begin
        cntD = CNT_W'(1);
      end else if (cntQ != '0) begin
        repD = repQ;
        if (REPEAT_DELAY == 0) begin
          cntD = cntQ;
        end else if (!repQ && cntQ == CNT_W'(REPEAT_DELAY)) begin
          tick = 1'b1;
          cntD = CNT_W'(1);
          repD = 1'b1;
        end else if (repQ && cntQ == CNT_W'(REPEAT_PERIOD)) begin
          tick = 1'b1;
          cntD = CNT_W'(1);
        end else begin
          cntD = cntQ + CNT_W'(1);
        end
      end
    end
  end

  assign stepUp   = (pressed || tick) && (keycode == KEY_NEXT);
  assign stepDown = (pressed || tick) && (keycode == KEY_PREV);
  assign stepHit  = findAlive(selQ, stepUp, WRAP, alive_mask);
  assign deadHit  = findAlive(selQ, 1'b1, 1'b1, alive_mask);

  // A step that finds no target still rescues a dead cursor via the upward wrapping search
  always_comb begin
    selD       = selQ;
    confIdxD   = confIdxQ;
    confPulseD = 1'b0;
    if (anyAlive) begin
      if ((stepUp || stepDown) && stepHit[IDX_W]) selD = stepHit[IDX_W-1:0];
      else if (!selValid)                         selD = deadHit[IDX_W-1:0];
    end
    if (pressed && keycode == KEY_CONFIRM && selValid) begin
      confIdxD   = selQ;
      confPulseD = 1'b1;
    end
    changedD = (selD != selQ);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      selQ       <= '0;
      confIdxQ   <= '0;
      changedQ   <= 1'b0;
      confPulseQ <= 1'b0;
      prevKeyQ   <= 8'h00;
      armedQ     <= 1'b0;
      cntQ       <= '0;
      repQ       <= 1'b0;
    end else begin
      selQ       <= selD;
      confIdxQ   <= confIdxD;
      changedQ   <= changedD;
      confPulseQ <= confPulseD;
      prevKeyQ   <= keycode;
      armedQ     <= 1'b1;
      cntQ       <= cntD;
      repQ       <= repD;
    end
  end

  assign sel_idx       = selQ;
  assign sel_valid     = selValid;
  assign sel_changed   = changedQ;
  assign confirm_pulse = confPulseQ;
  assign confirmed_idx = confIdxQ;

endmodule
